// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: data-memory access controller between the EX/MM stage and a ready/ack memory port.
module dm_access_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        dm_rw_ex_mm,
    input  logic [1:0]  dm_access_sz_ex_mm,
    input  logic [5:0]  opcode_ex_mm,
    input  logic [31:0] data_out_alu_ex_mm,
    input  logic [31:0] rd1_data_ex_mm,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic [31:0] rdata_out,
    output logic        rdata_valid,
    output logic        misalign_err,
    output logic        bus_err
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic [7:0]  cnt;
    logic [1:0]  sz_q, lane_q;
    logic        uns_q;
    logic        aligned, start, timeout;
    logic [3:0]  be_nx;
    logic [31:0] wdata_nx, shifted, ld_data;

    wire [1:0]  sz = dm_access_sz_ex_mm;
    wire [31:0] a  = data_out_alu_ex_mm;
    wire [31:0] d  = rd1_data_ex_mm;

    always_comb begin
        aligned  = sz == 2'b00 || (sz == 2'b01 && !a[0]) || (sz == 2'b10 && a[1:0] == 2'b00);
        start    = state == IDLE && req_valid && aligned;
        timeout  = cnt == TO_LAST;
        be_nx    = sz == 2'b00 ? 4'b0001 << a[1:0] : sz == 2'b01 ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
        wdata_nx = sz == 2'b00 ? {4{d[7:0]}} : sz == 2'b01 ? {2{d[15:0]}} : d;
        // lane select: shift the addressed byte/half down to bit 0, then extend
        shifted  = mem_rdata >> {lane_q, 3'b000};
        ld_data  = sz_q == 2'b00 ? {{24{!uns_q & shifted[7]}}, shifted[7:0]} :
                   sz_q == 2'b01 ? {{16{!uns_q & shifted[15]}}, shifted[15:0]} : mem_rdata;
        mem_req  = state == ACCESS;
        stall    = start || state == ACCESS;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? ACCESS : IDLE;
            ACCESS:  state_nx = (mem_ack || timeout) ? DONE : ACCESS;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            sz_q         <= '0;
            lane_q       <= '0;
            uns_q        <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_be       <= '0;
            mem_wdata    <= '0;
            rdata_out    <= '0;
            rdata_valid  <= 1'b0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            misalign_err <= state == IDLE && req_valid && !aligned;
            rdata_valid  <= state == ACCESS && mem_ack && !mem_we;
            bus_err      <= state == ACCESS && !mem_ack && timeout;
            if (start) begin
                cnt       <= '0;
                sz_q      <= sz;
                lane_q    <= a[1:0];
                uns_q     <= opcode_ex_mm == 6'h24 || opcode_ex_mm == 6'h25;
                mem_we    <= dm_rw_ex_mm;
                mem_addr  <= {a[31:2], 2'b00};
                mem_be    <= be_nx;
                mem_wdata <= wdata_nx;
            end
            // an ack arriving on the last allowed cycle still completes the access
            if (state == ACCESS) begin
                if (mem_ack) begin
                    if (!mem_we) rdata_out <= ld_data;
                end else begin
                    cnt <= cnt + 8'd1;
                    if (timeout) rdata_out <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl: table-driven scoreboard bench for dm_access_ctrl with TIMEOUT=4.
module tb_dm_access_ctrl;
    logic        clk = 1'b0;
    logic        rst, req_valid, dm_rw_ex_mm, mem_ack;
    logic [1:0]  dm_access_sz_ex_mm;
    logic [5:0]  opcode_ex_mm;
    logic [31:0] data_out_alu_ex_mm, rd1_data_ex_mm, mem_rdata;
    logic        mem_req, mem_we, stall, rdata_valid, misalign_err, bus_err;
    logic [31:0] mem_addr, mem_wdata, rdata_out;
    logic [3:0]  mem_be;

    int n_chk = 0;
    int n_err = 0;

    dm_access_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .dm_rw_ex_mm(dm_rw_ex_mm),
        .dm_access_sz_ex_mm(dm_access_sz_ex_mm), .opcode_ex_mm(opcode_ex_mm),
        .data_out_alu_ex_mm(data_out_alu_ex_mm), .rd1_data_ex_mm(rd1_data_ex_mm),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
        .rdata_out(rdata_out), .rdata_valid(rdata_valid), .misalign_err(misalign_err),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [1:0]  sz;
        logic [5:0]  op;
        logic [31:0] addr, wd, rd;
        int          dly;
        logic        mis;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic        e_valid, e_berr;
        logic [31:0] e_rdata;
        int          e_cyc;
    } vec_t;

    vec_t vecs[14];
    vec_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_vec(input vec_t v);
        vec_t e;
        int cyc;
        @(posedge clk); #1;
        req_valid = 1'b1; dm_rw_ex_mm = v.rw; dm_access_sz_ex_mm = v.sz; opcode_ex_mm = v.op;
        data_out_alu_ex_mm = v.addr; rd1_data_ex_mm = v.wd; mem_rdata = v.rd;
        exp_q.push_back(v);
        @(negedge clk);
        chk("req_stall", stall, !v.mis);
        chk("req_memreq", mem_req, 0);
        if (v.mis) begin
            @(posedge clk); #1 req_valid = 1'b0;
            @(negedge clk);
            e = exp_q.pop_front();
            chk("mis_pulse", misalign_err, 1);
            chk("mis_memreq", mem_req, 0);
            chk("mis_stall", stall, 0);
            @(posedge clk); @(negedge clk);
            chk("mis_drop", misalign_err, 0);
            chk("mis_memreq2", mem_req, 0);
            return;
        end
        @(posedge clk); #1;
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clk);
            if (!mem_req) break;
            chk("acc_addr", mem_addr, v.e_addr);
            chk("acc_be", mem_be, v.e_be);
            chk("acc_we", mem_we, v.rw);
            if (v.rw) chk("acc_wdata", mem_wdata, v.e_wd);
            chk("acc_stall", stall, 1);
            mem_ack = cyc == v.dly;
            @(posedge clk); #1 mem_ack = 1'b0;
            cyc++;
        end
        e = exp_q.pop_front();
        chk("done_cycles", cyc, e.e_cyc);
        chk("done_stall", stall, 0);
        chk("done_valid", rdata_valid, e.e_valid);
        chk("done_buserr", bus_err, e.e_berr);
        chk("done_rdata", rdata_out, e.e_rdata);
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        chk("post_noreissue", mem_req, 0);
        chk("post_valid", rdata_valid, 0);
        chk("post_buserr", bus_err, 0);
        chk("post_hold", rdata_out, e.e_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          rw   sz     op     addr          wd            rd            dly mis e_addr        e_be     e_wd          val  berr e_rdata       cyc
        vecs[0]  = '{1'b0, 2'b10, 6'h23, 32'h0000_0100, 32'hDEAD_BEEF, 32'h1122_3344, 0, 1'b0, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h1122_3344, 1};
        vecs[1]  = '{1'b0, 2'b00, 6'h20, 32'h0000_0103, 32'h0000_00A5, 32'h80FF_FFFF, 0, 1'b0, 32'h0000_0100, 4'b1000, 32'hA5A5_A5A5, 1'b1, 1'b0, 32'hFFFF_FF80, 1};
        vecs[2]  = '{1'b0, 2'b00, 6'h24, 32'h0000_0103, 32'h0000_00A5, 32'h80FF_FFFF, 0, 1'b0, 32'h0000_0100, 4'b1000, 32'hA5A5_A5A5, 1'b1, 1'b0, 32'h0000_0080, 1};
        vecs[3]  = '{1'b1, 2'b01, 6'h29, 32'h0000_0202, 32'h0000_BEEF, 32'h0000_0000, 1, 1'b0, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF, 1'b0, 1'b0, 32'h0000_0080, 2};
        vecs[4]  = '{1'b0, 2'b10, 6'h23, 32'h0000_0101, 32'h0000_0000, 32'h0000_0000, 0, 1'b1, 32'h0,         4'b0,    32'h0,         1'b0, 1'b0, 32'h0000_0080, 0};
        vecs[5]  = '{1'b0, 2'b01, 6'h21, 32'h0000_0102, 32'h0000_0000, 32'h8001_1234, 2, 1'b0, 32'h0000_0100, 4'b1100, 32'h0,         1'b1, 1'b0, 32'hFFFF_8001, 3};
        vecs[6]  = '{1'b0, 2'b01, 6'h25, 32'h0000_0100, 32'h0000_0000, 32'h8001_9234, 0, 1'b0, 32'h0000_0100, 4'b0011, 32'h0,         1'b1, 1'b0, 32'h0000_9234, 1};
        vecs[7]  = '{1'b0, 2'b10, 6'h23, 32'h0000_0300, 32'h0000_0000, 32'h5555_5555, -1, 1'b0, 32'h0000_0300, 4'b1111, 32'h0,        1'b0, 1'b1, 32'h0000_0000, 4};
        vecs[8]  = '{1'b0, 2'b10, 6'h23, 32'h0000_0304, 32'h0000_0000, 32'hCAFE_F00D, 3, 1'b0, 32'h0000_0304, 4'b1111, 32'h0,         1'b1, 1'b0, 32'hCAFE_F00D, 4};
        vecs[9]  = '{1'b0, 2'b01, 6'h21, 32'h0000_0103, 32'h0000_0000, 32'h0000_0000, 0, 1'b1, 32'h0,         4'b0,    32'h0,         1'b0, 1'b0, 32'hCAFE_F00D, 0};
        vecs[10] = '{1'b1, 2'b11, 6'h2B, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 1'b1, 32'h0,         4'b0,    32'h0,         1'b0, 1'b0, 32'hCAFE_F00D, 0};
        vecs[11] = '{1'b1, 2'b00, 6'h28, 32'h0000_0001, 32'h1234_5677, 32'h0000_0000, 0, 1'b0, 32'h0000_0000, 4'b0010, 32'h7777_7777, 1'b0, 1'b0, 32'hCAFE_F00D, 1};
        vecs[12] = '{1'b1, 2'b10, 6'h2B, 32'h0000_0040, 32'h0102_0304, 32'h0000_0000, -1, 1'b0, 32'h0000_0040, 4'b1111, 32'h0102_0304, 1'b0, 1'b1, 32'h0000_0000, 4};
        vecs[13] = '{1'b0, 2'b00, 6'h20, 32'h0000_0102, 32'h0000_0000, 32'h007F_0000, 0, 1'b0, 32'h0000_0100, 4'b0100, 32'h0,         1'b1, 1'b0, 32'h0000_007F, 1};

        rst = 1'b1; req_valid = 1'b0; dm_rw_ex_mm = 1'b0; dm_access_sz_ex_mm = 2'b00;
        opcode_ex_mm = 6'h0; data_out_alu_ex_mm = '0; rd1_data_ex_mm = '0; mem_rdata = '0; mem_ack = 1'b0;
        @(negedge clk);
        chk("rst_memreq", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_be", mem_be, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rdata", rdata_out, 0);
        chk("rst_flags", {rdata_valid, misalign_err, bus_err, stall}, 0);
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 14; i++) do_vec(vecs[i]);

        // ack while idle must not do anything
        @(posedge clk); #1 mem_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("idleack_memreq", mem_req, 0);
            chk("idleack_valid", rdata_valid, 0);
            chk("idleack_rdata", rdata_out, 32'h0000_007F);
        end
        @(posedge clk); #1 mem_ack = 1'b0;

        // reset in the second ACCESS cycle
        req_valid = 1'b1; dm_rw_ex_mm = 1'b0; dm_access_sz_ex_mm = 2'b10; opcode_ex_mm = 6'h23;
        data_out_alu_ex_mm = 32'h0000_0500; mem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstacc_memreq_before", mem_req, 1);
        #1 rst = 1'b1; req_valid = 1'b0;
        #1;
        chk("rstacc_memreq_async", mem_req, 0);
        chk("rstacc_stall", stall, 0);
        chk("rstacc_addr", mem_addr, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rstacc_novalid", rdata_valid, 0);
            chk("rstacc_nobuserr", bus_err, 0);
            chk("rstacc_rdata", rdata_out, 0);
        end
        do_vec('{1'b0, 2'b10, 6'h23, 32'h0000_0104, 32'h0, 32'h55AA_55AA, 0, 1'b0, 32'h0000_0104, 4'b1111, 32'h0, 1'b1, 1'b0, 32'h55AA_55AA, 1});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/dm_access_ctrl.md
DM_ACCESS_CTRL -- requirements
Module: dm_access_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the maximum ACCESS cycles without mem_ack; legal range 1..255.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid, input, 1 bit: the EX/MM stage holds a load or store.
REQ-005 SHALL have port dm_rw_ex_mm, input, 1 bit: 1 = store, 0 = load.
REQ-006 SHALL have port dm_access_sz_ex_mm, input, 2 bits: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-007 SHALL have port opcode_ex_mm, input, 6 bits: 6'h24 (LBU) and 6'h25 (LHU) zero-extend; all others sign-extend.
REQ-008 SHALL have port data_out_alu_ex_mm, input, 32 bits: byte address.
REQ-009 SHALL have port rd1_data_ex_mm, input, 32 bits: store data, right-justified.
REQ-010 SHALL have the following memory-side ports: mem_req (output, 1), mem_we (output, 1), mem_addr (output, 32, with [1:0]=00), mem_be (output, 4), mem_wdata (output, 32), mem_rdata (input, 32), mem_ack (input, 1).
REQ-011 SHALL have the following pipeline-side ports: stall (output, 1), rdata_out (output, 32), rdata_valid (output, 1), misalign_err (output, 1), bus_err (output, 1).

Function
REQ-012 SHALL implement the FSM states IDLE, ACCESS and DONE.
REQ-013 The access SHALL be aligned when the size is byte; half with addr[0]=0; or word with addr[1:0]=00. Size 11 SHALL always be misaligned.
REQ-014 In IDLE with req_valid=1 and an aligned access, the block SHALL register we, mem_addr={addr[31:2],2'b00}, mem_be and mem_wdata, and go to ACCESS.
REQ-015 In IDLE with req_valid=1 and a misaligned access, the block SHALL pulse misalign_err for 1 cycle (registered), issue no memory access and stay in IDLE; stall=0 throughout.
REQ-016 Byte enables (little-endian) SHALL be: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<{addr[1],1'b0}; word = 4'b1111.
REQ-017 Store data SHALL be lane-replicated: byte = {4{d[7:0]}}; half = {2{d[15:0]}}; word = d.
REQ-018 mem_req SHALL be 1 if and only if state = ACCESS, and all mem_* outputs SHALL stay stable while mem_req=1.
REQ-019 In ACCESS, mem_ack=1 SHALL move the FSM to DONE. For a load, the selected lane of mem_rdata, extended per REQ-007, SHALL be captured into rdata_out.
REQ-020 An 8-bit wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without ack. When it reaches TIMEOUT-1 without ack, the FSM SHALL go to DONE with bus_err=1 and rdata_out=0.
REQ-021 When mem_ack and the timeout coincide, the ack SHALL win: no bus_err.
REQ-022 stall SHALL be combinational: 1 when (IDLE and req_valid and aligned) or in ACCESS; 0 otherwise.
REQ-023 DONE SHALL last exactly 1 cycle with stall=0, so the pipeline advances. rdata_valid SHALL be 1 in DONE for loads only. bus_err SHALL be 1 in DONE only after a timeout. The FSM SHALL then return to IDLE unconditionally.
REQ-024 The block SHALL not evaluate req_valid in DONE, so the same instruction cannot be reissued.
REQ-025 mem_ack SHALL be ignored in IDLE and DONE.
REQ-026 Minimum latency, from the request cycle to rdata_valid, SHALL be 2 cycles when ack arrives in the first ACCESS cycle.
REQ-027 rdata_out SHALL hold its value until the next load completes.

Reset
REQ-028 On rst=1, state SHALL go immediately to IDLE; mem_req, mem_we, rdata_valid, misalign_err and bus_err SHALL be 0; mem_addr, mem_be, mem_wdata and rdata_out SHALL be 0; the counter SHALL be 0.
REQ-029 Reset in ACCESS SHALL abort the access without completion pulses, and mem_req SHALL drop asynchronously.

Verification
REQ-030 LW at 0x100, mem_rdata=0x11223344, ack on 1st ACCESS cycle -> mem_be=1111, stall for 2 cycles, rdata_valid with rdata_out=0x11223344.
REQ-031 LB at 0x103, mem_rdata=0x80FFFFFF -> mem_be=1000, rdata_out=0xFFFFFF80. LBU (opcode 24) at the same address -> rdata_out=0x00000080.
REQ-032 SH at 0x202 with data 0x0000BEEF -> mem_addr=0x200, mem_be=1100, mem_wdata=0xBEEFBEEF, mem_we=1, no rdata_valid.
REQ-033 LW at 0x101 -> misalign_err pulse, mem_req never 1, stall=0.
REQ-034 TIMEOUT=4, no ack -> mem_req for 4 cycles, then DONE with bus_err=1, rdata_out=0. Separately, ack arriving in the same cycle the timeout is reached -> bus_err=0.
REQ-035 rst asserted in the 2nd ACCESS cycle -> mem_req falls before the next edge; no rdata_valid; the next request proceeds normally.
